// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constants for the CNN layer sequencer.
package cnn_ctrl_pkg;

  // IDLE wait start | LOAD param fetch | RUN start pulse | WAIT layer busy | FINISH done pulse
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

  localparam int unsigned L_CONV = 0;
  localparam int unsigned L_POOL = 1;
  localparam int unsigned L_BN   = 2;
  localparam int unsigned L_ACT  = 3;
  localparam int unsigned L_FC   = 4;
  localparam int unsigned L_SM   = 5;

  localparam logic [5:0] DEFAULT_LOAD_MASK = 6'b010100;

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer watchdog: saturating up-counter with a limit compare; limit 0 disables it.
module layer_watchdog #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         timeout_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle the count reaches the limit, so a limit of N allows N enabled cycles.
  assign timeout_o = en_i && (limit_i != '0) && (cnt_q >= (limit_i - W'(1)));

endmodule

// File: rtl/layer_sequencer.sv
// Sequences conv->pool->bn->act->fc->softmax with parameter loads and a per-layer watchdog.
// Optional per-layer cycle counters are enabled by defining LAYER_SEQUENCER_PERF_EN.
module layer_sequencer #(
  parameter int                    NUM_LAYERS = 6,
  parameter logic [NUM_LAYERS-1:0] LOAD_MASK  = cnn_ctrl_pkg::DEFAULT_LOAD_MASK,
  parameter int                    WDOG_W     = 20,
  parameter logic [WDOG_W-1:0]     WDOG_LIMIT = 20'hFFFFF,
  parameter int                    IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [IDX_W-1:0]      err_layer,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  load_req,
  output logic [IDX_W-1:0]      load_sel,
  input  logic                  load_ack,
  output logic [IDX_W-1:0]      cur_layer
`ifdef LAYER_SEQUENCER_PERF_EN
  ,
  input  logic [IDX_W-1:0]      perf_sel,
  output logic [31:0]           perf_cnt
`endif
);

  import cnn_ctrl_pkg::*;

  seq_state_e            state_q, state_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      err_layer_q, err_layer_d;
  logic                  busy_q, done_q, load_req_q;
  logic [IDX_W-1:0]      load_sel_q;
  logic [NUM_LAYERS-1:0] layer_start_q;
  logic                  wd_clr, wd_en, wd_timeout;

  layer_watchdog #(.W(WDOG_W)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .limit_i  (WDOG_LIMIT),
    .timeout_o(wd_timeout)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    err_d       = err_q;
    err_layer_d = err_layer_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          cur_d   = '0;
          state_d = LOAD_MASK[0] ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (abort)         state_d = ST_IDLE;
        else if (load_ack) state_d = ST_RUN;
      end
      ST_RUN: begin
        wd_clr  = 1'b1;
        state_d = abort ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // Priority: abort, then layer completion, then timeout.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (layer_done[cur_q]) begin
          if (cur_q == IDX_W'(NUM_LAYERS - 1)) begin
            state_d = ST_FINISH;
          end else begin
            cur_d   = cur_q + IDX_W'(1);
            state_d = LOAD_MASK[cur_d] ? ST_LOAD : ST_RUN;
          end
        end else if (wd_timeout) begin
          err_d       = 1'b1;
          err_layer_d = cur_q;
          state_d     = ST_IDLE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_q         <= '0;
      err_q         <= 1'b0;
      err_layer_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_req_q    <= 1'b0;
      load_sel_q    <= '0;
      layer_start_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      err_q         <= err_d;
      err_layer_q   <= err_layer_d;
      busy_q        <= (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_WAIT);
      done_q        <= (state_d == ST_FINISH);
      load_req_q    <= (state_d == ST_LOAD);
      if (state_d == ST_LOAD) load_sel_q <= cur_d;
      layer_start_q <= (state_d == ST_RUN) ? (NUM_LAYERS'(1) << cur_d) : '0;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_layer   = err_layer_q;
  assign load_req    = load_req_q;
  assign load_sel    = load_sel_q;
  assign layer_start = layer_start_q;
  assign cur_layer   = cur_q;

`ifdef LAYER_SEQUENCER_PERF_EN
  logic [31:0] perf_q [NUM_LAYERS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) perf_q[i] <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      for (int i = 0; i < NUM_LAYERS; i++) perf_q[i] <= '0;
    end else if (((state_q == ST_LOAD) || (state_q == ST_WAIT)) && (perf_q[cur_q] != 32'hFFFF_FFFF)) begin
      perf_q[cur_q] <= perf_q[cur_q] + 32'd1;
    end
  end

  assign perf_cnt = (32'(perf_sel) < 32'(NUM_LAYERS)) ? perf_q[perf_sel] : 32'd0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: randomized layer/load responders, event-level reference model.
module tb_layer_sequencer;

  localparam int WDOG = 16;

  typedef enum int {EV_LOAD, EV_START, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       idx;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic       busy, done, err, load_req, load_ack;
  logic [2:0] err_layer, load_sel, cur_layer;
  logic [5:0] layer_start, layer_done;
  logic [5:0] resp_done = '0, stray_done = '0;
  logic       resp_ack = 1'b0, stray_ack = 1'b0;
`ifdef LAYER_SEQUENCER_PERF_EN
  logic [2:0]  perf_sel = 3'd0;
  logic [31:0] perf_cnt;
`endif

  assign layer_done = resp_done | stray_done;
  assign load_ack   = resp_ack | stray_ack;

  layer_sequencer #(.WDOG_LIMIT(20'(WDOG))) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_layer  (err_layer),
    .layer_start(layer_start),
    .layer_done (layer_done),
    .load_req   (load_req),
    .load_sel   (load_sel),
    .load_ack   (load_ack),
    .cur_layer  (cur_layer)
`ifdef LAYER_SEQUENCER_PERF_EN
    ,
    .perf_sel   (perf_sel),
    .perf_cnt   (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int  n_checks = 0, n_pass = 0;
  int  cyc = 0;
  ev_t exp_q[$];
  logic [5:0] mask_tb = 6'b010100;
  int  dly[6];
  int  ack_dly = 2;
  int  hang_layer = -1;
  bit  ack_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  function automatic int oh_idx(logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push_ev(ev_kind_e k, int i);
    ev_t e;
    e.kind = k;
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  // Reference model: the event trace one inference should produce, hanging at layer 'hang' if >= 0.
  task automatic push_run(int hang);
    for (int i = 0; i < 6; i++) begin
      if (mask_tb[i]) push_ev(EV_LOAD, i);
      push_ev(EV_START, i);
      if (i == hang) begin
        push_ev(EV_ERR, i);
        return;
      end
    end
    push_ev(EV_DONE, 0);
  endtask

  task automatic mon_pop(ev_kind_e k, int i);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d idx %0d expected none", k, i);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind == k && e.idx == i) n_pass++;
    else $display("FAIL event_order: got kind %0d idx %0d expected kind %0d idx %0d", k, i, e.kind, e.idx);
  endtask

  // Monitor: every DUT output event is compared against the scoreboard queue.
  initial begin
    logic lr_prev = 1'b0, err_prev = 1'b0;
    int   last_start = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (layer_start != '0) begin
          chk("start_onehot", longint'($onehot(layer_start)), 1);
          mon_pop(EV_START, oh_idx(layer_start));
          last_start = cyc;
        end
        if (load_req && !lr_prev) mon_pop(EV_LOAD, int'(load_sel));
        if (done) begin
          chk("busy_low_with_done", busy, 0);
          mon_pop(EV_DONE, 0);
        end
        if (err && !err_prev) begin
          mon_pop(EV_ERR, int'(err_layer));
          chk("wdog_latency", cyc - last_start, WDOG + 1);
          chk("busy_low_on_err", busy, 0);
        end
      end
      lr_prev  = load_req;
      err_prev = err;
    end
  end

  // Responder: layers finish dly[i] cycles after their start pulse; loads ack ack_dly cycles after request.
  initial begin
    int done_cnt = 0, done_idx = 0, ack_cnt = 0;
    bit ack_pend = 1'b0;
    forever begin
      @(negedge clk);
      resp_done = '0;
      resp_ack  = 1'b0;
      if (!busy) begin
        done_cnt = 0;
        ack_cnt  = 0;
        ack_pend = 1'b0;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) resp_done[done_idx] = 1'b1;
        end
        if (layer_start != '0 && oh_idx(layer_start) != hang_layer) begin
          done_idx = oh_idx(layer_start);
          done_cnt = dly[done_idx];
        end
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) resp_ack = 1'b1;
        end
        if (!load_req) ack_pend = 1'b0;
        else if (!ack_pend && ack_en) begin
          ack_pend = 1'b1;
          ack_cnt  = ack_dly;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_by_start", err, 0);
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk({nm, "_idle_timeout"}, 0, 1);
    tick(3);
    chk({nm, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_start(int i);
    int n = 0;
    while (!layer_start[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_layer_start", i, -1);
  endtask

  task automatic check_all_zero(string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_load_req"}, load_req, 0);
    chk({nm, "_layer_start"}, layer_start, 0);
    chk({nm, "_cur_layer"}, cur_layer, 0);
    chk({nm, "_err_layer"}, err_layer, 0);
    chk({nm, "_load_sel"}, load_sel, 0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) dly[i] = 3;
    #3 rst_n = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Nominal run.
    push_run(-1);
    do_start();
    wait_idle("nominal");
    chk("nominal_err", err, 0);

    // fc hangs until the watchdog fires.
    hang_layer = 4;
    dly[1] = 10;
    push_run(4);
    do_start();
    wait_idle("timeout");
    chk("timeout_err", err, 1);
    chk("timeout_err_layer", err_layer, 4);
    chk("timeout_busy", busy, 0);
`ifdef LAYER_SEQUENCER_PERF_EN
    perf_sel = 3'd1;
    #1 chk("perf_pool", perf_cnt, 10);
    perf_sel = 3'd7;
    #1 chk("perf_out_of_range", perf_cnt, 0);
`endif
    hang_layer = -1;
    dly[1] = 3;
    push_run(-1);
    do_start();
    wait_idle("after_timeout");

    // Abort while bn load is pending; a late ack must not restart anything.
    ack_en = 1'b0;
    push_ev(EV_START, 0);
    push_ev(EV_START, 1);
    push_ev(EV_LOAD, 2);
    do_start();
    begin
      int n = 0;
      while (!(load_req && load_sel == 3'd2) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("wait_bn_load", 0, 1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_load_req", load_req, 0);
    chk("abort_busy", busy, 0);
    tick(3);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    tick(3);
    chk("late_ack_busy", busy, 0);
    wait_idle("abort_load");
    ack_en = 1'b1;
    push_run(-1);
    do_start();
    wait_idle("after_abort");

    // Stray done and mid-run start during conv; abort together with pool's done.
    dly[0] = 8;
    hang_layer = 1;
    push_ev(EV_START, 0);
    push_ev(EV_START, 1);
    do_start();
    wait_start(0);
    tick(2);
    stray_done = 6'b001000;
    start = 1'b1;
    @(negedge clk);
    stray_done = '0;
    start = 1'b0;
    chk("stray_cur_layer", cur_layer, 0);
    wait_start(1);
    tick(2);
    stray_done = 6'b000010;
    abort = 1'b1;
    @(negedge clk);
    stray_done = '0;
    abort = 1'b0;
    chk("abort_wins_busy", busy, 0);
    wait_idle("stray_abort");
    hang_layer = -1;
    dly[0] = 3;

    // Asynchronous reset while waiting on act.
    hang_layer = 3;
    for (int i = 0; i < 4; i++) begin
      if (mask_tb[i]) push_ev(EV_LOAD, i);
      push_ev(EV_START, i);
    end
    do_start();
    wait_start(3);
    tick(2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    hang_layer = -1;
    wait_idle("reset_mid_wait");
    push_run(-1);
    do_start();
    wait_idle("after_reset");

    // Randomized runs, some with a hung layer.
    for (int r = 0; r < 8; r++) begin
      int h;
      for (int i = 0; i < 6; i++) dly[i] = int'($urandom_range(1, 10));
      ack_dly = int'($urandom_range(1, 4));
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      hang_layer = h;
      push_run(h);
      do_start();
      wait_idle("random");
      chk("random_err", err, (h >= 0) ? 1 : 0);
      if (h >= 0) chk("random_err_layer", err_layer, h);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Central controller for the classification CNN datapath. Runs the layer chain conv -> pool -> bn -> act -> fc -> softmax strictly in order, one layer active at a time.
- Before starting a layer that needs parameters (bn, fc), it requests a parameter load and waits for the acknowledge.
- Reports busy/done/error to the host side and includes a per-layer watchdog.

Parameters:
- NUM_LAYERS, 6, number of sequenced layers; index 0 = conv ... 5 = softmax.
- LOAD_MASK, 6'b010100, bit i set = layer i needs a parameter load before start (bn=2, fc=4).
- WDOG_W, 20, width of the watchdog counter.
- WDOG_LIMIT, 20'hFFFFF, cycles a layer may run before timeout; 0 disables the watchdog.
- IDX_W, 3, width of layer index fields; must satisfy 2**IDX_W >= NUM_LAYERS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run one inference.
- abort  in  1  single-cycle cancel of the running inference.
- busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- done  out  1  one-cycle pulse when softmax completes.
- err  out  1  sticky watchdog error; cleared by the next accepted start or by reset.
- err_layer  out  IDX_W  index of the layer that timed out.
- layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse to layer i.
- layer_done  in  NUM_LAYERS  one-cycle completion pulse from layer i.
- load_req  out  1  level; held high until load_ack.
- load_sel  out  IDX_W  layer whose weights/biases/stats are to be loaded; stable while load_req is high.
- load_ack  in  1  one-cycle acknowledge that the load is complete.
- cur_layer  out  IDX_W  index of the layer currently being loaded or run.

Behaviour:
- Reset: state IDLE; busy, done, err, load_req, layer_start = 0; err_layer, load_sel, cur_layer = 0; watchdog = 0.
- States: IDLE, LOAD, RUN, WAIT, FINISH.
- IDLE
  - start=1 -> clear err, cur_layer=0.
  - Next state is LOAD if LOAD_MASK[0], else RUN.
  - start while not in IDLE is ignored.
- LOAD
  - load_req=1, load_sel=cur_layer.
  - load_ack -> load_req drops next cycle; go to RUN.
  - load_ack outside LOAD is ignored.
- RUN
  - Exactly one cycle: layer_start[cur_layer]=1, watchdog cleared.
  - Next state WAIT.
- WAIT
  - Watchdog increments every cycle.
  - layer_done[cur_layer]=1 and cur_layer==NUM_LAYERS-1 -> FINISH.
  - layer_done[cur_layer]=1 otherwise -> cur_layer+1, then LOAD or RUN per LOAD_MASK.
  - layer_done bits for any other layer are ignored.
  - Watchdog reaching WDOG_LIMIT (when nonzero) -> err=1, err_layer=cur_layer, go to IDLE, no done.
  - If layer_done and timeout occur in the same cycle, done wins.
- FINISH: done=1 for one cycle, then IDLE. busy drops in the same cycle done is high.
- abort
  - Valid in LOAD, RUN or WAIT: the next state is IDLE and load_req drops.
  - No layer_start or done is issued; err is unchanged.
  - abort beats a coincident layer_done or load_ack.
  - abort in IDLE or FINISH is ignored.
- Minimum latency: start to done = 1 + sum over layers of (RUN 1 + WAIT ≥1) + 2 per loaded layer + FINISH 1.
- The watchdog saturates and never wraps.
- Asynchronous reset mid-operation returns to the reset values immediately; layer_start is never glitched high.

Optional Feature:
- Macro: LAYER_SEQUENCER_PERF_EN.
- Defined:
  - Adds inputs perf_sel (IDX_W) and output perf_cnt (32).
  - Per-layer 32-bit cycle counters are cleared on an accepted start.
  - Each counter increments during that layer's LOAD and WAIT cycles and saturates at 32'hFFFFFFFF.
  - perf_cnt = counter[perf_sel], combinational; perf_sel out of range reads 0.
- Undefined: the ports and counters are absent.

Decomposition:
- Package cnn_ctrl_pkg:
  - state enum;
  - layer index constants L_CONV=0, L_POOL=1, L_BN=2, L_ACT=3, L_FC=4, L_SM=5;
  - default LOAD_MASK.
- One sub-module: layer_watchdog (clear, enable, limit compare, saturating count, timeout flag).
- Perf counters stay inline.

Test Plan:
- Nominal run: start; every layer returns done 3 cycles after its start; load_ack 2 cycles after load_req.
  -> layer_start pulses in order 0..5; load_req only with load_sel=2 and load_sel=4; exactly one done; busy falls with done; err=0.
- Timeout: WDOG_LIMIT=16; fc never returns done.
  -> err=1 and err_layer=4 after 16 WAIT cycles; busy=0; no done. The next start clears err.
- abort during LOAD of bn (load_req high).
  -> next cycle IDLE and load_req=0; a load_ack arriving later is ignored; a fresh start runs from conv.
- Stray and same-cycle events: during conv, pulse layer_done[3]; start asserted mid-run; layer_done[1] together with abort.
  -> stray done ignored; start ignored; abort wins and no layer_start[2] is issued.
- Reset mid-WAIT on layer 3: deassert rst_n.
  -> all outputs return to 0 asynchronously; after release, start completes a normal run.
- LAYER_SEQUENCER_PERF_EN: pool done 10 cycles after start.
  -> perf_sel=1 reads 10; perf_sel=7 reads 0.
